// File: rtl/note_playback.sv
// Sequencer that plays a snapshot of eight captured notes as one-hot key enables,
// timed by beat_tick, with a one-cycle silent gap between slots and optional looping.
module note_playback (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_in,
  input  logic        beat_tick,
  input  logic [79:0] note_y,
  input  logic [23:0] note_dur,
  output logic [7:0]  key_out,
  output logic [10:0] cursor_x,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  localparam logic [9:0]  Y_EMPTY  = 10'd50;
  localparam logic [10:0] CUR_HOME = 11'd240;

  state_t      state;
  logic [2:0]  idx, cnt;
  logic [79:0] snap_y;
  logic [23:0] snap_dur;
  logic [2:0]  nidx;
  logic [9:0]  sy [8];
  logic [2:0]  sd [8];

  for (genvar k = 0; k < 8; k++) begin : g_slot
    assign sy[k] = snap_y[10*k +: 10];
    assign sd[k] = snap_dur[3*k +: 3];
  end

  assign nidx = idx + 3'd1;

  // Staff y position to key; anything unrecognised plays as a rest.
  function automatic logic [7:0] key_of(input logic [9:0] y);
    case (y)
      10'd485: key_of = 8'h01;
      10'd460: key_of = 8'h02;
      10'd435: key_of = 8'h04;
      10'd410: key_of = 8'h08;
      10'd385: key_of = 8'h10;
      10'd360: key_of = 8'h20;
      10'd335: key_of = 8'h40;
      10'd310: key_of = 8'h80;
      default: key_of = 8'h00;
    endcase
  endfunction

  function automatic logic [10:0] cur_of(input logic [2:0] i);
    case (i)
      3'd0:    cur_of = 11'd240;
      3'd1:    cur_of = 11'd362;
      3'd2:    cur_of = 11'd487;
      3'd3:    cur_of = 11'd612;
      3'd4:    cur_of = 11'd737;
      3'd5:    cur_of = 11'd862;
      3'd6:    cur_of = 11'd987;
      default: cur_of = 11'd1112;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      snap_y   <= '0;
      snap_dur <= '0;
      key_out  <= '0;
      cursor_x <= CUR_HOME;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !stop) begin
          snap_y   <= note_y;
          snap_dur <= note_dur;
          idx      <= '0;
          busy     <= 1'b1;
          cursor_x <= CUR_HOME;
          if (note_y[9:0] == Y_EMPTY) begin
            state   <= DONE;
            done    <= 1'b1;
            key_out <= '0;
          end else begin
            state   <= PLAY;
            cnt     <= note_dur[2:0];
            key_out <= key_of(note_y[9:0]);
          end
        end
        PLAY: begin
          if (stop) begin
            state    <= DONE;
            done     <= 1'b1;
            key_out  <= '0;
            cursor_x <= CUR_HOME;
          end else if (beat_tick) begin
            if (cnt == 3'd0) begin
              state   <= GAP;
              key_out <= '0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        GAP: begin
          // Slot 8 has no successor: only loop_in may bring playback back to slot 1.
          if (stop) begin
            state    <= DONE;
            done     <= 1'b1;
            cursor_x <= CUR_HOME;
          end else if (idx != 3'd7 && sy[nidx] != Y_EMPTY) begin
            state    <= PLAY;
            idx      <= nidx;
            cnt      <= sd[nidx];
            key_out  <= key_of(sy[nidx]);
            cursor_x <= cur_of(nidx);
          end else if (loop_in) begin
            state    <= PLAY;
            idx      <= '0;
            cnt      <= sd[0];
            key_out  <= key_of(sy[0]);
            cursor_x <= CUR_HOME;
          end else begin
            state    <= DONE;
            done     <= 1'b1;
            cursor_x <= CUR_HOME;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_playback.sv
// Scoreboard bench: stimulus queues expected output segments (value + run length),
// a negedge monitor splits the DUT outputs into segments and checks them in order.
module tb_note_playback;
  logic        clk_in = 1'b0, rst_in = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop_in = 1'b0, beat_tick = 1'b1;
  logic [79:0] note_y;
  logic [23:0] note_dur;
  logic [7:0]  key_out;
  logic [10:0] cursor_x;
  logic        busy, done;

  note_playback dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .stop(stop),
    .loop_in(loop_in), .beat_tick(beat_tick), .note_y(note_y),
    .note_dur(note_dur), .key_out(key_out), .cursor_x(cursor_x),
    .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0]  key;
    logic [10:0] cur;
    logic        busy;
    logic        done;
  } obs_t;
  typedef struct {
    obs_t o;
    int   len;   // 0 = run length not checked
  } seg_t;

  localparam int YT  [8] = '{485, 460, 435, 410, 385, 360, 335, 310};
  localparam int CUR [8] = '{240, 362, 487, 612, 737, 862, 987, 1112};

  seg_t exp_q[$];
  int   compared = 0, mismatched = 0, seg_no = 0;
  bit   flush = 1'b0;

  task automatic exp_seg(input logic [7:0] k, input logic [10:0] c,
                         input logic b, input logic d, input int len);
    seg_t s;
    s.o   = '{key: k, cur: c, busy: b, done: d};
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic idle_seg();
    exp_seg(8'h00, 11'd240, 1'b0, 1'b0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic emit(input obs_t o, input int len);
    seg_t e;
    compared++;
    seg_no++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL seg%0d unexpected: key=%h cur=%0d busy=%b done=%b len=%0d",
               seg_no, o.key, o.cur, o.busy, o.done, len);
    end else begin
      e = exp_q.pop_front();
      if (o !== e.o || (e.len != 0 && len != e.len)) begin
        mismatched++;
        $display("FAIL seg%0d: got key=%h cur=%0d busy=%b done=%b len=%0d, want key=%h cur=%0d busy=%b done=%b len=%0d",
                 seg_no, o.key, o.cur, o.busy, o.done, len,
                 e.o.key, e.o.cur, e.o.busy, e.o.done, e.len);
      end
    end
  endtask

  obs_t s_now, pend;
  int   run = 0;
  bit   have = 1'b0;

  always @(negedge clk_in) begin
    s_now = '{key: key_out, cur: cursor_x, busy: busy, done: done};
    if (!have) begin
      pend = s_now; run = 1; have = 1'b1;
    end else if (s_now !== pend || flush) begin
      emit(pend, run);
      pend = s_now; run = 1;
    end else begin
      run++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 8; k++) note_y[k*10 +: 10] = 10'd50;
    note_dur = '0;
  endtask

  task automatic set_slot(input int k, input int y, input int d);
    note_y[(k-1)*10 +: 10] = y[9:0];
    note_dur[(k-1)*3 +: 3] = d[2:0];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    clear_slots();
    idle_seg();
    #12;
    chk("rst_key", key_out, 0);
    chk("rst_cursor", cursor_x, 240);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk_in); #1 rst_in = 1'b1;
    cyc(3);

    // Three notes with durations 0,1,2 under a continuous tick
    clear_slots();
    set_slot(1, 485, 0); set_slot(2, 435, 1); set_slot(3, 310, 2);
    exp_seg(8'h01, 11'd240, 1, 0, 1); exp_seg(8'h00, 11'd240, 1, 0, 1);
    exp_seg(8'h04, 11'd362, 1, 0, 2); exp_seg(8'h00, 11'd362, 1, 0, 1);
    exp_seg(8'h80, 11'd487, 1, 0, 3); exp_seg(8'h00, 11'd487, 1, 0, 1);
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(14);

    // Empty first slot
    clear_slots();
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(4);

    // Rest in slot 2 (dur 2), merged with its gap: 3 + 1 cycles at cursor 362
    clear_slots();
    set_slot(1, 485, 0); set_slot(2, 285, 2);
    exp_seg(8'h01, 11'd240, 1, 0, 1); exp_seg(8'h00, 11'd240, 1, 0, 1);
    exp_seg(8'h00, 11'd362, 1, 0, 4);
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(12);

    // Sparse ticks: dur 1 lasts until the second tick
    clear_slots();
    set_slot(1, 410, 1);
    beat_tick = 1'b0;
    exp_seg(8'h08, 11'd240, 1, 0, 6); exp_seg(8'h00, 11'd240, 1, 0, 1);
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(2); beat_tick = 1'b1; cyc(1); beat_tick = 1'b0;
    cyc(2); beat_tick = 1'b1; cyc(1); beat_tick = 1'b0;
    cyc(5);
    beat_tick = 1'b1;

    // start and note_y changes during playback are ignored
    clear_slots();
    set_slot(1, 485, 3); set_slot(2, 360, 0);
    exp_seg(8'h01, 11'd240, 1, 0, 4); exp_seg(8'h00, 11'd240, 1, 0, 1);
    exp_seg(8'h20, 11'd362, 1, 0, 1); exp_seg(8'h00, 11'd362, 1, 0, 1);
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(1);
    clear_slots(); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(10);

    // All eight slots, looping; stop lands with a tick on pass-2 slot 3
    for (int k = 0; k < 8; k++) set_slot(k + 1, YT[k], 0);
    loop_in = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < ((p == 0) ? 8 : 2); k++) begin
        exp_seg(8'h01 << k, CUR[k][10:0], 1, 0, 1);
        exp_seg(8'h00, CUR[k][10:0], 1, 0, 1);
      end
    exp_seg(8'h04, 11'd487, 1, 0, 1);
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(20); stop = 1'b1;
    cyc(1);  stop = 1'b0;
    cyc(4);
    loop_in = 1'b0;

    // All eight slots without loop: ends after slot 8, no wrap
    for (int k = 0; k < 8; k++) begin
      exp_seg(8'h01 << k, CUR[k][10:0], 1, 0, 1);
      exp_seg(8'h00, CUR[k][10:0], 1, 0, 1);
    end
    exp_seg(8'h00, 11'd240, 1, 1, 1); idle_seg();
    pulse_start();
    cyc(22);

    // stop alone, and start together with stop, do nothing in IDLE
    stop = 1'b1; cyc(2);
    start = 1'b1; cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(3);

    // Asynchronous reset in the middle of a long note
    clear_slots();
    set_slot(1, 485, 7);
    exp_seg(8'h01, 11'd240, 1, 0, 3); idle_seg();
    pulse_start();
    cyc(3);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_key", key_out, 0);
    chk("arst_cursor", cursor_x, 240);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    cyc(6);

    flush = 1'b1;
    @(negedge clk_in);
    #1 flush = 1'b0;
    chk("queue_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/note_playback.md
NOTE_PLAYBACK -- requirements
Module: note_playback

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 clk_in  input  1  system clock; all state changes on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 start  input  1  single-cycle pulse; begins playback of the stored sequence.
REQ-005 stop  input  1  abort playback.
REQ-006 loop_in  input  1  1 = restart from slot 1 after the last valid slot.
REQ-007 beat_tick  input  1  single-cycle tempo pulse; the time base for note durations.
REQ-008 note_y  input  80  eight 10-bit staff y positions; slot k (1..8) is bits [10k-1:10k-10], as produced by free-play capture.
REQ-009 note_dur  input  24  eight 3-bit duration codes; slot k is bits [3k-1:3k-3].
REQ-010 key_out  output  8  one-hot tone enable; bit 0 = low C ... bit 7 = high C.
REQ-011 cursor_x  output  11  x position of the slot currently playing.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  single-cycle pulse at end of playback.

Function
REQ-014 States SHALL be IDLE, PLAY, GAP and DONE.
REQ-015 In IDLE, start=1 with stop=0 SHALL latch note_y and note_dur into internal snapshot registers on the same edge; later input changes SHALL NOT affect that playback.
REQ-016 y decode SHALL map 485,460,435,410,385,360,335,310 to keys 0..7.
REQ-017 y=50 SHALL mark an empty slot, meaning end of sequence.
REQ-018 Any other y SHALL be a rest: slot plays with key_out=0 for its duration.
REQ-019 Start handling:
- Slot 1 empty: go to DONE.
- Otherwise: go to PLAY at slot 1 with remaining-beats counter = duration code (code d lasts d+1 beat_ticks).
REQ-020 In PLAY, key_out SHALL be one-hot of the decoded key (or 0 for a rest), registered, starting the cycle after the entering edge.
REQ-021 In PLAY, each beat_tick with counter>0 SHALL decrement the counter; beat_tick with counter=0 SHALL go to GAP.
REQ-022 GAP SHALL last exactly one clk cycle with key_out=0, then select the next slot:
- Next slot valid and index<=8: go to PLAY and load its duration.
- Else loop_in=1 (sampled in GAP): go to PLAY at slot 1.
- Else: go to DONE.
REQ-023 DONE SHALL assert done for one cycle, with key_out=0, then go to IDLE.
REQ-024 cursor_x SHALL be 240 in IDLE and DONE.
REQ-025 In PLAY and GAP, cursor_x SHALL be 240,362,487,612,737,862,987,1112 for slots 1..8.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 stop=1 in PLAY or GAP SHALL go to DONE on that edge, overriding a coincident beat_tick or start.
REQ-028 stop=1 in IDLE SHALL have no effect.
REQ-029 beat_tick in IDLE, GAP or DONE SHALL be ignored.
REQ-030 The slot index SHALL be 3 bits; advancing past slot 8 SHALL never wrap silently, only via loop_in per REQ-022.

Reset
REQ-031 While rst_in=0, outputs SHALL be: key_out=0, cursor_x=240, busy=0, done=0.
REQ-032 While rst_in=0, state SHALL be IDLE; slot index, counter and snapshot registers SHALL be 0.
REQ-033 Reset asserted mid-playback SHALL abort immediately with no done pulse.
REQ-034 After rst_in rises, the block SHALL wait for a fresh start.

Verification
REQ-035 Slots 1-3 y=485,435,310 with dur 0,1,2, slot 4 y=50, start, continuous beat_tick ->
- key_out 0x01 for 1 tick, 0x04 for 2 ticks, 0x80 for 3 ticks;
- one-cycle 0 gaps between notes;
- cursor 240,362,487;
- then done pulse and busy=0.
REQ-036 Slot 1 y=50, start -> done pulse 1 cycle later; key_out never nonzero.
REQ-037 Slot 2 y=285 (rest) -> key_out=0 during slot 2 for its duration; cursor 362.
REQ-038 All 8 slots valid, loop_in=1 -> after slot 8 GAP returns to slot 1 (cursor 240); no done until stop; stop coincident with beat_tick -> DONE, done pulse.
REQ-039 start mid-PLAY and note_y changed mid-PLAY -> no effect on sequence.
REQ-040 rst_in=0 asynchronously mid-note -> key_out=0, cursor_x=240, busy=0 immediately, no done pulse.
